// File: rtl/adder_init_pkg.sv
// Shared types and constants for the adder traffic initiator.
package adder_init_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FINISH} state_t;

  // Per-transaction operand steps: op_a += A_STEP, op_b -= B_STEP.
  localparam int A_STEP = 1;
  localparam int B_STEP = 3;
endpackage

// File: rtl/adder_init_if.sv
// Operand/result handshake bundle between the initiator (master) and the adder (slave).
interface adder_init_if #(parameter int WIDTH = 8) ();
  logic             req_val;
  logic             req_rdy;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rsp_val;
  logic             rsp_rdy;
  logic [WIDTH:0]   rsp_sum;

  modport master (
    output req_val, op_a, op_b, rsp_rdy,
    input  req_rdy, rsp_val, rsp_sum
  );

  modport slave (
    input  req_val, op_a, op_b, rsp_rdy,
    output req_rdy, rsp_val, rsp_sum
  );
endinterface

// File: rtl/adder_init_opgen.sv
// Operand generator: loads op_a=seed / op_b=~seed, then steps once per accepted result.
module adder_init_opgen
  import adder_init_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b
);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (load) begin
      op_a <= seed;
      op_b <= ~seed;
    end else if (step) begin
      op_a <= op_a + WIDTH'(A_STEP);
      op_b <= op_b - WIDTH'(B_STEP);
    end
  end

endmodule

// File: rtl/adder_initiator.sv
// Adder traffic source and self-checker. Optional handshake watchdog under
// ADDER_INIT_TIMEOUT_EN; without it the initiator waits indefinitely.
module adder_initiator
  import adder_init_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
`ifdef ADDER_INIT_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic [WIDTH-1:0] seed,
  adder_init_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [WIDTH:0]   expected;
  logic [WIDTH-1:0] op_a, op_b;
  logic             req_val, rsp_rdy;
  logic             zero_done;
  logic             start_acc, run_go, req_fire, rsp_fire, last_rsp, wd_fire;

  assign start_acc = (state == IDLE) && start;
  assign run_go    = start_acc && (num_txn != '0);
  assign req_fire  = req_val && bus.req_rdy;
  assign rsp_fire  = rsp_rdy && bus.rsp_val;
  assign last_rsp  = (txn_count + CNT_W'(1)) == num_lat;

  assign bus.req_val = req_val;
  assign bus.rsp_rdy = rsp_rdy;
  assign bus.op_a    = op_a;
  assign bus.op_b    = op_b;

  // num_txn==0 is answered with a bare done pulse without leaving IDLE.
  assign done = (state == FINISH) || zero_done;

  adder_init_opgen #(.WIDTH(WIDTH)) u_opgen (
    .clk  (clk),
    .rst  (rst),
    .load (run_go),
    .step (rsp_fire),
    .seed (seed),
    .op_a (op_a),
    .op_b (op_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on state only; req_rdy/rsp_val only steer next state.
  always_comb begin
    state_nxt = state;
    req_val   = 1'b0;
    rsp_rdy   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run_go) state_nxt = ISSUE;
      end
      ISSUE: begin
        req_val = 1'b1;
        if (bus.req_rdy)  state_nxt = WAIT_RSP;
        else if (wd_fire) state_nxt = FINISH;
      end
      WAIT_RSP: begin
        rsp_rdy = 1'b1;
        if (bus.rsp_val)  state_nxt = last_rsp ? FINISH : ISSUE;
        else if (wd_fire) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat   <= '0;
      expected  <= '0;
      txn_count <= '0;
      err_count <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= start_acc && (num_txn == '0);
      if (start_acc) begin
        txn_count <= '0;
        err_count <= '0;
      end
      if (run_go) num_lat <= num_txn;
      if (req_fire) expected <= {1'b0, op_a} + {1'b0, op_b};
      if (rsp_fire) begin
        txn_count <= txn_count + CNT_W'(1);
        if (bus.rsp_sum != expected) err_count <= err_count + CNT_W'(1);
      end
    end
  end

`ifdef ADDER_INIT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_fire = ((state == ISSUE) || (state == WAIT_RSP)) &&
                   (wd_cnt == WD_W'(TIMEOUT - 1));
  assign timeout = timeout_q;

  // Restart on every state change so each handshake gets a full TIMEOUT window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt != state)                  wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT - 1))   wd_cnt <= wd_cnt + WD_W'(1);
      if (start_acc)                            timeout_q <= 1'b0;
      else if (wd_fire && !req_fire && !rsp_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/adder_initiator.md
# adder_initiator

Request-side driver for the synchronous adder datapath. Issues a programmed number of add transactions over the valid/ready operand handshake, accepts each sum over the result handshake, and checks it against a locally computed expected value. Sits opposite the adder's control FSM: its request outputs feed the adder's input handshake, and its response inputs take the adder's output handshake. It serves as the on-chip traffic source and self-checker for the adder.

## Interface
- WIDTH, 8, operand width; sum is WIDTH+1 bits
- CNT_W, 8, width of transaction counts
- TIMEOUT, 16, max cycles waiting for any single handshake (only with timeout feature)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- num_txn  in  CNT_W  transactions per run; latched on start
- seed  in  WIDTH  initial operand seed; latched on start
- req_val  out  1  operand valid (to adder val_in)
- req_rdy  in  1  adder ready for operands (adder rdy_in)
- op_a  out  WIDTH  operand A
- op_b  out  WIDTH  operand B
- rsp_val  in  1  adder result valid (adder val_out)
- rsp_rdy  out  1  initiator ready for result (to adder rdy_out)
- rsp_sum  in  WIDTH+1  adder result
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- txn_count  out  CNT_W  completed transactions in current/last run
- err_count  out  CNT_W  result mismatches in current/last run
- timeout  out  1  sticky: run aborted by watchdog; cleared on next accepted start

## Operation
- States: IDLE, ISSUE, WAIT_RSP, FINISH.
- IDLE: start=1, num_txn!=0 -> latch num_txn/seed, clear txn_count/err_count/timeout, op_a=seed, op_b=~seed, go ISSUE. start=1, num_txn==0 -> done pulse, counters cleared, stay IDLE.
- ISSUE: req_val=1, op_a/op_b held stable. On req_val&&req_rdy: register expected = {1'b0,op_a}+{1'b0,op_b} (WIDTH+1 bits, no truncation), go WAIT_RSP.
- WAIT_RSP: rsp_rdy=1. On rsp_val&&rsp_rdy: if rsp_sum!=expected, err_count++; txn_count++; op_a+=1, op_b-=3 (mod 2^WIDTH); if new txn_count==num_txn go FINISH else ISSUE.
- FINISH: done=1 for one cycle, go IDLE.
- Exactly one transaction outstanding; rsp_val in ISSUE/IDLE is ignored (rsp_rdy=0).
- start while busy ignored. Counters saturate never (bounded by num_txn).
- busy=1 in ISSUE, WAIT_RSP, FINISH.

## Timing
- Reset: state IDLE; req_val, rsp_rdy, busy, done, timeout = 0; op_a, op_b, txn_count, err_count = 0.
- rst mid-run: abort immediately to reset values next edge, no done pulse.
- start accepted at edge N -> req_val=1 from cycle N+1.
- req_val, rsp_rdy are decoded from registered state only (no combinational path from req_rdy/rsp_val).
- Request handshake completes in the cycle both high; rsp_rdy=1 from the next cycle.
- Last response accepted at edge M -> done=1 during cycle M+1, busy=0 from M+2.
- Against the adder's fixed 4-phase schedule (ready phase, two compute phases, valid phase): one transaction per 4 cycles steady-state; first request may wait up to 4 cycles for req_rdy.

## Configuration
- ADDER_INIT_TIMEOUT_EN defined: watchdog counter cleared on entry to ISSUE/WAIT_RSP; if handshake not completed within TIMEOUT cycles, set timeout=1, go FINISH (done pulses, txn_count reflects completed transactions only).
- Undefined: no watchdog logic; timeout tied to 0; initiator waits indefinitely.

## Structure
- Package adder_init_pkg: state enum type (IDLE, ISSUE, WAIT_RSP, FINISH), operand step constants (A_STEP=1, B_STEP=3).
- Sub-module adder_init_opgen: holds op_a/op_b, load-from-seed and step-on-accept; top module keeps FSM, expected register, counters, watchdog.

## Test plan
- Reset: assert rst 2 cycles mid-run -> all outputs 0, state IDLE, no done.
- Clean run: WIDTH=8, seed=0x10, num_txn=3, model adder correct -> operands (0x10,0xEF),(0x11,0xEC),(0x12,0xE9); txn_count=3, err_count=0, done pulse once.
- Carry-out: seed=0xFF -> op_a=0xFF, op_b=0x00, expected 0x0FF; then op_a=0x00, op_b=0xFD, expected 0x0FD; adder returns matching 9-bit sums -> err_count=0.
- Error injection: model adder returns sum^1 on transaction 2 of 4 -> err_count=1, txn_count=4.
- Back-pressure: hold req_rdy low 5 cycles, rsp_val delayed 7 cycles -> op_a/op_b and req_val stable throughout, run completes correctly; start pulsed mid-run ignored.
- Timeout (ADDER_INIT_TIMEOUT_EN, TIMEOUT=16): req_rdy never asserted -> timeout=1 and done after 16 cycles in ISSUE, txn_count=0; num_txn=0 start -> immediate done, busy stays 0.
